// File: rtl/nibble_sort_ctrl.sv
// nibble_sort_ctrl
// Sorts four unsigned 4-bit operands with an early-exit bubble sort that
// performs exactly one compare-and-swap per SORT cycle. The result, the
// number of swaps and the number of compares are registered on entry to
// DONE and held until the next completed sort. DESCEND selects the order.

module nibble_sort_ctrl #(
    parameter bit DESCEND = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] din0,
    input  logic [3:0] din1,
    input  logic [3:0] din2,
    input  logic [3:0] din3,
    output logic       busy,
    output logic       done,
    output logic [3:0] dout0,
    output logic [3:0] dout1,
    output logic [3:0] dout2,
    output logic [3:0] dout3,
    output logic [2:0] swap_cnt,
    output logic [2:0] cmp_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SORT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // True when the pair (a, b) at positions i, i+1 violates the requested
    // order. Equal values are never out of order, so they are never swapped.
    function automatic logic out_of_order(
        input logic [3:0] a,
        input logic [3:0] b,
        input logic       desc
    );
        logic res;
        if (desc) begin
            res = (a < b);
        end else begin
            res = (a > b);
        end
        return res;
    endfunction

    // Control state
    state_t          state_r;
    state_t          state_s;

    // Working registers: r_r[k] holds element k of the array being sorted
    logic [3:0][3:0] r_r;
    logic [3:0][3:0] r_s;
    logic [1:0]      p_r;
    logic [1:0]      p_s;
    logic [1:0]      i_r;
    logic [1:0]      i_s;
    logic            swapped_r;
    logic            swapped_s;
    logic [2:0]      swap_int_r;
    logic [2:0]      swap_int_s;
    logic [2:0]      cmp_int_r;
    logic [2:0]      cmp_int_s;

    // Compare datapath
    logic [3:0]      a_s;
    logic [3:0]      b_s;
    logic            ooo_s;
    logic            last_pos_s;
    logic            pass_swapped_s;
    logic            load_out_s;

    // Registered outputs
    logic            busy_r;
    logic            done_r;
    logic [3:0][3:0] dout_r;
    logic [2:0]      swap_cnt_r;
    logic [2:0]      cmp_cnt_r;

    // Select the adjacent pair at position i and evaluate its ordering
    always_comb begin
        a_s            = r_r[i_r];
        b_s            = r_r[i_r + 2'd1];
        ooo_s          = out_of_order(a_s, b_s, DESCEND);
        last_pos_s     = (i_r == (2'd2 - p_r));
        pass_swapped_s = swapped_r | ooo_s;
    end

    // Next-state logic, working-register updates and output load strobe
    always_comb begin
        state_s    = state_r;
        r_s        = r_r;
        p_s        = p_r;
        i_s        = i_r;
        swapped_s  = swapped_r;
        swap_int_s = swap_int_r;
        cmp_int_s  = cmp_int_r;
        load_out_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    r_s        = {din3, din2, din1, din0};
                    p_s        = 2'd0;
                    i_s        = 2'd0;
                    swapped_s  = 1'b0;
                    swap_int_s = 3'd0;
                    cmp_int_s  = 3'd0;
                    state_s    = ST_SORT;
                end else begin
                    state_s    = ST_IDLE;
                end
            end

            ST_SORT: begin
                cmp_int_s = cmp_int_r + 3'd1;
                if (ooo_s) begin
                    r_s[i_r]         = b_s;
                    r_s[i_r + 2'd1]  = a_s;
                    swap_int_s       = swap_int_r + 3'd1;
                    swapped_s        = 1'b1;
                end else begin
                    swapped_s        = swapped_r;
                end

                if (last_pos_s) begin
                    // A pass with no swap means the array is already ordered
                    if ((p_r == 2'd2) || !pass_swapped_s) begin
                        state_s    = ST_DONE;
                        load_out_s = 1'b1;
                    end else begin
                        p_s        = p_r + 2'd1;
                        i_s        = 2'd0;
                        swapped_s  = 1'b0;
                    end
                end else begin
                    i_s = i_r + 2'd1;
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Working registers, pass/position indices and internal counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_r        <= {4{4'd0}};
            p_r        <= 2'd0;
            i_r        <= 2'd0;
            swapped_r  <= 1'b0;
            swap_int_r <= 3'd0;
            cmp_int_r  <= 3'd0;
        end else begin
            r_r        <= r_s;
            p_r        <= p_s;
            i_r        <= i_s;
            swapped_r  <= swapped_s;
            swap_int_r <= swap_int_s;
            cmp_int_r  <= cmp_int_s;
        end
    end

    // Output registers: status tracks the next state, results load on DONE entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            dout_r     <= {4{4'd0}};
            swap_cnt_r <= 3'd0;
            cmp_cnt_r  <= 3'd0;
        end else begin
            busy_r <= (state_s == ST_SORT);
            done_r <= load_out_s;
            if (load_out_s) begin
                dout_r     <= r_s;
                swap_cnt_r <= swap_int_s;
                cmp_cnt_r  <= cmp_int_s;
            end else begin
                dout_r     <= dout_r;
                swap_cnt_r <= swap_cnt_r;
                cmp_cnt_r  <= cmp_cnt_r;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign dout0    = dout_r[0];
    assign dout1    = dout_r[1];
    assign dout2    = dout_r[2];
    assign dout3    = dout_r[3];
    assign swap_cnt = swap_cnt_r;
    assign cmp_cnt  = cmp_cnt_r;

endmodule

// File: tb/tb_nibble_sort_ctrl.sv
// Self-checking bench for nibble_sort_ctrl: an ascending and a descending
// instance share all inputs; a transaction-level model predicts busy, done
// and the held results every cycle, and directed cases pin literal values.

module tb_nibble_sort_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] din0, din1, din2, din3;

    logic       busy_a, done_a, busy_d, done_d;
    logic [3:0] da0, da1, da2, da3, dd0, dd1, dd2, dd3;
    logic [2:0] swa, cma, swd, cmd;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    nibble_sort_ctrl #(.DESCEND(1'b0)) dut_asc (
        .clk(clk), .rst_n(rst_n), .start(start),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .busy(busy_a), .done(done_a),
        .dout0(da0), .dout1(da1), .dout2(da2), .dout3(da3),
        .swap_cnt(swa), .cmp_cnt(cma)
    );

    nibble_sort_ctrl #(.DESCEND(1'b1)) dut_desc (
        .clk(clk), .rst_n(rst_n), .start(start),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .busy(busy_d), .done(done_d),
        .dout0(dd0), .dout1(dd1), .dout2(dd2), .dout3(dd3),
        .swap_cnt(swd), .cmp_cnt(cmd)
    );

    // Per-instance views, index 0 = ascending, 1 = descending
    logic [15:0] dv [2];
    logic [2:0]  sv [2];
    logic [2:0]  cv [2];
    logic        bv [2];
    logic        ov [2];
    assign dv[0] = {da3, da2, da1, da0};
    assign dv[1] = {dd3, dd2, dd1, dd0};
    assign sv[0] = swa;
    assign sv[1] = swd;
    assign cv[0] = cma;
    assign cv[1] = cmd;
    assign bv[0] = busy_a;
    assign bv[1] = busy_d;
    assign ov[0] = done_a;
    assign ov[1] = done_d;

    typedef struct packed {
        logic [15:0] v;
        logic [2:0]  sw;
        logic [2:0]  cmp;
    } res_t;

    // Early-exit bubble sort on a plain int array, counting compares and swaps
    function automatic res_t sort_model(input logic [15:0] d, input bit desc);
        int   a [4];
        int   t;
        int   sw = 0;
        int   cmp = 0;
        bit   any;
        res_t r;
        for (int k = 0; k < 4; k++) a[k] = int'(d[4*k +: 4]);
        for (int p = 0; p < 3; p++) begin
            any = 1'b0;
            for (int i = 0; i <= 2 - p; i++) begin
                cmp++;
                if (desc ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
                    t = a[i]; a[i] = a[i+1]; a[i+1] = t;
                    sw++;
                    any = 1'b1;
                end
            end
            if (!any) break;
        end
        for (int k = 0; k < 4; k++) r.v[4*k +: 4] = 4'(a[k]);
        r.sw  = 3'(sw);
        r.cmp = 3'(cmp);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: phase 0 idle, 1 sorting (cmp cycles), 2 done pulse
    int   m_phase [2] = '{0, 0};
    int   m_cnt   [2] = '{0, 0};
    res_t m_pend  [2] = '{'0, '0};
    res_t m_out   [2] = '{'0, '0};

    // Advance the model on every clock edge; reset clears everything at once
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_phase[k] <= 0;
                m_cnt[k]   <= 0;
                m_pend[k]  <= '0;
                m_out[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (m_phase[k])
                    0: if (start === 1'b1) begin
                        m_pend[k]  <= sort_model({din3, din2, din1, din0}, k == 1);
                        m_cnt[k]   <= 1;
                        m_phase[k] <= 1;
                    end
                    1: if (m_cnt[k] == int'(m_pend[k].cmp)) begin
                        m_phase[k] <= 2;
                        m_out[k]   <= m_pend[k];
                    end else begin
                        m_cnt[k] <= m_cnt[k] + 1;
                    end
                    default: m_phase[k] <= 0;
                endcase
            end
        end
    end

    // Compare every output of both instances against the model each cycle
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("busy[%0d]", k), 32'(bv[k]), 32'(m_phase[k] == 1));
            chk($sformatf("done[%0d]", k), 32'(ov[k]), 32'(m_phase[k] == 2));
            chk($sformatf("dout[%0d]", k), 32'(dv[k]), 32'(m_out[k].v));
            chk($sformatf("swap_cnt[%0d]", k), 32'(sv[k]), 32'(m_out[k].sw));
            chk($sformatf("cmp_cnt[%0d]", k), 32'(cv[k]), 32'(m_out[k].cmp));
        end
    end

    // One sort on both instances with literal expectations for model and DUT
    task automatic directed(input string nm, input logic [15:0] d,
                            input logic [15:0] ea, input int esa, input int eca,
                            input logic [15:0] ed, input int esd, input int ecd);
        res_t r;
        int   cyc;
        int   seen [2];
        int   es [2];
        int   ec [2];
        logic [15:0] ev [2];
        ev[0] = ea; es[0] = esa; ec[0] = eca;
        ev[1] = ed; es[1] = esd; ec[1] = ecd;
        for (int k = 0; k < 2; k++) begin
            r = sort_model(d, k == 1);
            chk($sformatf("%s model_v[%0d]", nm, k), 32'(r.v), 32'(ev[k]));
            chk($sformatf("%s model_sw[%0d]", nm, k), 32'(r.sw), 32'(es[k]));
            chk($sformatf("%s model_cmp[%0d]", nm, k), 32'(r.cmp), 32'(ec[k]));
        end
        repeat (2) @(posedge clk);
        #1;
        {din3, din2, din1, din0} = d;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        {din3, din2, din1, din0} = ~d;
        cyc = 1;
        seen[0] = -1; seen[1] = -1;
        chk($sformatf("%s busy_c1", nm), 32'(busy_a & busy_d), 32'd1);
        while ((seen[0] < 0 || seen[1] < 0) && cyc < 20) begin
            for (int k = 0; k < 2; k++) begin
                if (ov[k] && seen[k] < 0) begin
                    seen[k] = cyc;
                    chk($sformatf("%s dout[%0d]", nm, k), 32'(dv[k]), 32'(ev[k]));
                    chk($sformatf("%s swap[%0d]", nm, k), 32'(sv[k]), 32'(es[k]));
                    chk($sformatf("%s cmp[%0d]", nm, k), 32'(cv[k]), 32'(ec[k]));
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        for (int k = 0; k < 2; k++)
            chk($sformatf("%s done_cycle[%0d]", nm, k), 32'(seen[k]), 32'(ec[k] + 1));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        {din3, din2, din1, din0} = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy_a | busy_d), 32'd0);
        chk("reset dout", 32'({dv[0], dv[1]}), 32'd0);
        rst_n = 1'b1;

        // din listed din3..din0 in each literal
        directed("presorted", 16'h4321, 16'h4321, 0, 3, 16'h1234, 6, 6);
        directed("reverse",   16'h2479, 16'h9742, 6, 6, 16'h2479, 0, 3);
        directed("dups",      16'h5055, 16'h5550, 2, 6, 16'h0555, 1, 5);
        directed("extremes",  16'h0F0F, 16'hFF00, 3, 6, 16'h00FF, 1, 5);

        // Start held high, din changed during the first sort
        begin
            int cyc;
            repeat (2) @(posedge clk);
            #1;
            {din3, din2, din1, din0} = 16'h2479;
            start = 1'b1;
            cyc = 0;
            while (cyc < 16) begin
                @(posedge clk); #1;
                cyc++;
                if (cyc == 2) {din3, din2, din1, din0} = 16'h0213;
                if (cyc == 7) begin
                    chk("hs first done", 32'(done_a), 32'd1);
                    chk("hs first dout", 32'(dv[0]), 32'h9742);
                end
                if (cyc == 9) chk("hs second busy", 32'(busy_a), 32'd1);
                if (cyc == 15) begin
                    chk("hs second done", 32'(done_a), 32'd1);
                    chk("hs second dout", 32'(dv[0]), 32'h3210);
                    chk("hs second swap", 32'(swa), 32'd5);
                    chk("hs second cmp", 32'(cma), 32'd6);
                    start = 1'b0;
                end
            end
            repeat (10) @(posedge clk);
        end

        // Reset mid-sort then restart
        #1;
        {din3, din2, din1, din0} = 16'h2479;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst busy", 32'(busy_a | busy_d), 32'd0);
        chk("midrst done", 32'(done_a | done_d), 32'd0);
        chk("midrst dout", 32'({dv[0], dv[1]}), 32'd0);
        chk("midrst cnts", 32'({swa, cma, swd, cmd}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        directed("restart", 16'h2479, 16'h9742, 6, 6, 16'h2479, 0, 3);

        // Randomized traffic with occasional asynchronous reset pulses
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                logic [3:0] v;
                case ($urandom_range(0, 3))
                    0: v = 4'h0;
                    1: v = 4'hF;
                    default: v = 4'($urandom_range(0, 15));
                endcase
                case (k)
                    0: din0 = v;
                    1: din1 = v;
                    2: din2 = v;
                    default: din3 = v;
                endcase
            end
            start = ($urandom_range(0, 2) != 0);
            rst_n = ($urandom_range(0, 149) != 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/nibble_sort_ctrl.md
NIBBLE_SORT_CTRL -- requirements
Module: nibble_sort_ctrl

Interface
REQ-001 The block SHALL have parameter DESCEND, default 0: 0 sorts ascending (dout0 smallest), 1 sorts descending (dout0 largest).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: sort request, sampled only in IDLE.
REQ-005 The block SHALL have ports din0..din3, input, 4 bits each: unsigned operands, captured on an accepted start.
REQ-006 The block SHALL have port busy, output, 1 bit: high while in SORT.
REQ-007 The block SHALL have port done, output, 1 bit: single-cycle pulse marking result valid.
REQ-008 The block SHALL have ports dout0..dout3, output, 4 bits each: sorted result, registered.
REQ-009 The block SHALL have port swap_cnt, output, 3 bits: swaps performed in the last completed sort (0..6).
REQ-010 The block SHALL have port cmp_cnt, output, 3 bits: compares performed in the last completed sort (3..6).

Function
REQ-011 The FSM SHALL have exactly three states (IDLE, SORT, DONE) and SHALL perform exactly one 4-bit unsigned compare per SORT cycle, between working registers r[i] and r[i+1].
REQ-012 In IDLE with start=1, the block SHALL latch din0..din3 into r0..r3, clear pass index p, position i, the per-pass swap flag and internal counters, and enter SORT next cycle.
REQ-013 In SORT, r[i] and r[i+1] SHALL be swapped when out of order (DESCEND=0: r[i] > r[i+1]; DESCEND=1: r[i] < r[i+1]); equal values SHALL never be swapped.
REQ-014 Position i SHALL run 0..2-p within pass p; when i reaches 2-p, the block SHALL enter DONE if p=2 or no swap occurred in that pass, else set p=p+1 and i=0.
REQ-015 Latency: with start high in cycle 0 and C compare cycles (3 <= C <= 6), compares SHALL occur in cycles 1..C and done SHALL be high in cycle C+1 only.
REQ-016 On entering DONE, dout0..dout3 SHALL load r0..r3 and swap_cnt/cmp_cnt SHALL load their internal counts; these outputs SHALL hold until the next DONE.
REQ-017 From DONE the block SHALL return to IDLE unconditionally; a start held high SHALL be accepted in the cycle after done (back-to-back sorts).
REQ-018 start SHALL be ignored in SORT and DONE, and din changes after capture SHALL NOT affect the sort in progress.
REQ-019 The compare SHALL be purely unsigned, so 4'hF is greater than 4'h0; no sign or wrap interpretation is permitted.

Reset
REQ-020 While rst_n=0, state SHALL be IDLE, and busy, done, dout0..dout3, swap_cnt, cmp_cnt, r0..r3, p and i SHALL all be 0.
REQ-021 Reset asserted mid-sort SHALL abort immediately with no done pulse; dout, swap_cnt and cmp_cnt SHALL read 0.
REQ-022 After rst_n deasserts, the block SHALL accept start on the first rising edge at which it is sampled high.

Verification
REQ-023 Presorted: DESCEND=0, din=1,2,3,4, start in cycle 0 -> busy in cycles 1-3, done in cycle 4, dout=1,2,3,4, swap_cnt=0, cmp_cnt=3.
REQ-024 Reverse order: DESCEND=0, din=9,7,4,2 -> done in cycle 7, dout=2,4,7,9, swap_cnt=6, cmp_cnt=6.
REQ-025 Duplicates and extremes: din=5,5,0,5 -> dout=0,5,5,5, swap_cnt=2, cmp_cnt=6; din=F,0,F,0 -> dout=0,0,F,F.
REQ-026 Descending: DESCEND=1, din=1,2,3,4 -> dout=4,3,2,1, swap_cnt=6, cmp_cnt=6, done in cycle 7.
REQ-027 Handshake: start held high continuously with din changed during SORT -> second sort captures din in the cycle after done, and the first result is unaffected by the din change.
REQ-028 Reset mid-sort: din=9,7,4,2, rst_n low in cycle 3 -> busy=0 and all outputs 0 at once, no done; a restart after release completes normally.
